// File: rtl/regfile_scoreboard.sv
// Parametrised multi-read-port register file with a per-register busy
// scoreboard. Decode/issue reads operands and allocates destinations;
// writeback writes results and releases the destination's busy bit.
//
// Interface timing (all handshakes are single-cycle, no valid/ready pairs):
//   - alloc_en_i is a request; the allocation takes effect at the next rising
//     edge only when alloc_ok_o is 1 in the same cycle. A refused request
//     changes no state and must be held and retried by the issuer.
//   - wr_en_i is an unconditional strobe; the write is always accepted.
//   - Reads are combinational and see same-cycle write data when BYPASS=1.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       alloc_en_i,
  input  logic [ADDR_W-1:0]          alloc_addr_i,
  output logic                       alloc_ok_o,
  input  logic                       flush_i,
  output logic [ADDR_W:0]            busy_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  // Architectural storage and scoreboard state.
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

  // Decoded control for this cycle.
  logic wr_is_zero;
  logic wr_eff;
  logic alloc_is_zero;
  logic alloc_wr_hit;
  logic alloc_ok;
  logic alloc_acc;
  logic cnt_inc;
  logic cnt_dec;

  // Register 0 is hardwired only when ZERO_REG is set; otherwise it is an
  // ordinary register.
  assign wr_is_zero    = (ZERO_REG != 0) && (wr_addr_i == '0);
  assign alloc_is_zero = (ZERO_REG != 0) && (alloc_addr_i == '0);

  // A write to the hardwired zero register is dropped entirely.
  assign wr_eff = wr_en_i && !wr_is_zero;

  // A writeback landing on the allocation target this cycle frees it, so the
  // re-allocation can be accepted in the same cycle.
  assign alloc_wr_hit = wr_en_i && (wr_addr_i == alloc_addr_i);

  // Acceptance: never during a flush; always for the zero register (it is a
  // no-op); otherwise the target must be free or being freed right now.
  always_comb begin
    alloc_ok = 1'b0;
    if (flush_i) begin
      alloc_ok = 1'b0;
    end else if (alloc_is_zero) begin
      alloc_ok = 1'b1;
    end else begin
      alloc_ok = !busy_q[alloc_addr_i] || alloc_wr_hit;
    end
  end

  assign alloc_ok_o = alloc_ok;

  // Only accepted allocations of a real register touch the scoreboard.
  assign alloc_acc = alloc_en_i && alloc_ok && !alloc_is_zero;

  // Counter bookkeeping mirrors the busy-bit transitions exactly:
  //  inc: a free register becomes busy through allocation.
  //  dec: a busy register is released by a write that no same-cycle
  //       allocation re-claims.
  assign cnt_inc = alloc_acc && !busy_q[alloc_addr_i];
  assign cnt_dec = wr_eff && busy_q[wr_addr_i] &&
                   !(alloc_acc && (alloc_addr_i == wr_addr_i));

  // Next busy vector: flush clears everything; otherwise writeback clears and
  // allocation sets, with allocation taking priority on the same address.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wr_eff) begin
        busy_d[wr_addr_i] = 1'b0;
      end
      if (alloc_acc) begin
        busy_d[alloc_addr_i] = 1'b1;
      end
    end
  end

  // Next busy count: held in step with popcount(busy) one transition at a time.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (flush_i) begin
      busy_cnt_d = '0;
    end else begin
      busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  // Register storage; data is written even during a flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_eff) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Independent combinational read ports with optional write bypass.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zero_hit;
    logic              byp_hit;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr     = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);
    assign byp_hit  = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr);

    // Priority: hardwired zero, then forwarded write data, then storage.
    always_comb begin
      data = regs_q[addr];
      busy = busy_q[addr];
      if (zero_hit) begin
        data = '0;
        busy = 1'b0;
      end else if (byp_hit) begin
        data = wr_data_i;
        busy = 1'b0;
      end
    end

    assign rd_data_o[k*DATA_W +: DATA_W] = data;
    assign rd_busy_o[k]                  = busy;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard with default parameters: directed scenarios
// followed by randomized traffic, all checked against an array-based model.
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  // ---------------- clock / reset / DUT ----------------
  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_busy_o;
  logic                     wr_en_i;
  logic [ADDR_W-1:0]        wr_addr_i;
  logic [DATA_W-1:0]        wr_data_i;
  logic                     alloc_en_i;
  logic [ADDR_W-1:0]        alloc_addr_i;
  logic                     alloc_ok_o;
  logic                     flush_i;
  logic [ADDR_W:0]          busy_cnt_o;

  always #5 clk_i = ~clk_i;

  regfile_scoreboard dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_busy_o    (rd_busy_o),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .alloc_en_i   (alloc_en_i),
    .alloc_addr_i (alloc_addr_i),
    .alloc_ok_o   (alloc_ok_o),
    .flush_i      (flush_i),
    .busy_cnt_o   (busy_cnt_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_busy [DEPTH];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [DATA_W-1:0] m_rd_data(input int a);
    if (a == 0) return '0;
    if (wr_en_i && int'(wr_addr_i) == a) return wr_data_i;
    return m_mem[a];
  endfunction

  function automatic logic m_rd_busy(input int a);
    if (a == 0) return 1'b0;
    if (wr_en_i && int'(wr_addr_i) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic m_alloc_ok();
    if (flush_i) return 1'b0;
    if (alloc_addr_i == 0) return 1'b1;
    return !m_busy[alloc_addr_i] || (wr_en_i && wr_addr_i == alloc_addr_i);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  // Apply one cycle's inputs just after the falling edge, settle 1 time unit.
  task automatic drive(input logic we, input int wa, input logic [DATA_W-1:0] wd,
                       input logic ae, input int aa, input logic fl,
                       input int r0, input int r1);
    @(negedge clk_i);
    wr_en_i      = we;
    wr_addr_i    = ADDR_W'(wa);
    wr_data_i    = wd;
    alloc_en_i   = ae;
    alloc_addr_i = ADDR_W'(aa);
    flush_i      = fl;
    rd_addr_i    = {ADDR_W'(r1), ADDR_W'(r0)};
    #1;
  endtask

  task automatic idle(input int r0, input int r1);
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0, r0, r1);
  endtask

  // Fold the currently driven inputs into the model, then take the edge.
  task automatic tick();
    logic ok;
    ok = m_alloc_ok();
    if (wr_en_i && wr_addr_i != 0) m_mem[wr_addr_i] = wr_data_i;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else begin
      if (wr_en_i && wr_addr_i != 0) m_busy[wr_addr_i] = 1'b0;
      if (alloc_en_i && ok && alloc_addr_i != 0) m_busy[alloc_addr_i] = 1'b1;
    end
    @(posedge clk_i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) begin
      idle(i, DEPTH - 1 - i);
      vectors++;
      if (rd_data_o !== '0) begin
        miscompares++;
        $display("FAIL reset_data addr %0d: got %h want 0", i, rd_data_o);
      end
      vectors++;
      if (rd_busy_o !== '0) begin
        miscompares++;
        $display("FAIL reset_busy addr %0d: got %b want 00", i, rd_busy_o);
      end
    end
    vectors++;
    if (busy_cnt_o !== '0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d want 0", busy_cnt_o);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 5, 6);
    vectors++;
    if (rd_data_o[31:0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h want deadbeef", rd_data_o[31:0]);
    end
    tick();
    idle(6, 5);
    vectors++;
    if (rd_data_o[63:32] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL bypass_stored: got %h want deadbeef", rd_data_o[63:32]);
    end
    vectors++;
    if (rd_data_o[31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_neighbour: got %h want 0", rd_data_o[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 0, 32'h1234, 1'b0, 0, 1'b0, 0, 0);
    vectors++;
    if (rd_data_o !== '0) begin
      miscompares++;
      $display("FAIL zero_bypass: got %h want 0", rd_data_o);
    end
    tick();
    drive(1'b0, 0, '0, 1'b1, 0, 1'b0, 0, 0);
    vectors++;
    if (rd_data_o !== '0) begin
      miscompares++;
      $display("FAIL zero_read: got %h want 0", rd_data_o);
    end
    vectors++;
    if (alloc_ok_o !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_alloc_ok: got %b want 1", alloc_ok_o);
    end
    tick();
    idle(0, 0);
    vectors++;
    if (busy_cnt_o !== '0 || rd_busy_o !== '0) begin
      miscompares++;
      $display("FAIL zero_alloc_state: cnt %0d busy %b want 0 00", busy_cnt_o, rd_busy_o);
    end
  endtask

  task automatic test_alloc();
    drive(1'b0, 0, '0, 1'b1, 7, 1'b0, 7, 0);
    vectors++;
    if (alloc_ok_o !== 1'b1) begin
      miscompares++;
      $display("FAIL alloc_first_ok: got %b want 1", alloc_ok_o);
    end
    tick();
    drive(1'b0, 0, '0, 1'b1, 7, 1'b0, 7, 0);
    vectors++;
    if (busy_cnt_o !== 6'd1) begin
      miscompares++;
      $display("FAIL alloc_cnt: got %0d want 1", busy_cnt_o);
    end
    vectors++;
    if (rd_busy_o !== 2'b01) begin
      miscompares++;
      $display("FAIL alloc_rd_busy: got %b want 01", rd_busy_o);
    end
    vectors++;
    if (alloc_ok_o !== 1'b0) begin
      miscompares++;
      $display("FAIL alloc_refused: got %b want 0", alloc_ok_o);
    end
    tick();
    drive(1'b1, 7, 32'hA5A5_0007, 1'b1, 7, 1'b0, 7, 7);
    vectors++;
    if (alloc_ok_o !== 1'b1) begin
      miscompares++;
      $display("FAIL alloc_with_write_ok: got %b want 1", alloc_ok_o);
    end
    vectors++;
    if (rd_busy_o !== 2'b00) begin
      miscompares++;
      $display("FAIL alloc_with_write_bypass_busy: got %b want 00", rd_busy_o);
    end
    tick();
    idle(7, 0);
    vectors++;
    if (busy_cnt_o !== 6'd1 || rd_busy_o !== 2'b01) begin
      miscompares++;
      $display("FAIL alloc_realloc_state: cnt %0d busy %b want 1 01", busy_cnt_o, rd_busy_o);
    end
    vectors++;
    if (rd_data_o[31:0] !== 32'hA5A5_0007) begin
      miscompares++;
      $display("FAIL alloc_realloc_data: got %h want a5a50007", rd_data_o[31:0]);
    end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      drive(1'b0, 0, '0, 1'b1, r, 1'b0, 1, 2);
      tick();
    end
    drive(1'b0, 0, '0, 1'b1, 4, 1'b1, 1, 3);
    vectors++;
    if (busy_cnt_o !== 6'd4) begin
      miscompares++;
      $display("FAIL flush_pre_cnt: got %0d want 4", busy_cnt_o);
    end
    vectors++;
    if (alloc_ok_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_alloc_ok: got %b want 0", alloc_ok_o);
    end
    tick();
    idle(4, 7);
    vectors++;
    if (busy_cnt_o !== '0 || rd_busy_o !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_state: cnt %0d busy %b want 0 00", busy_cnt_o, rd_busy_o);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 0, '0, 1'b1, 9, 1'b0, 9, 5);
    tick();
    idle(9, 5);
    vectors++;
    if (rd_busy_o[0] !== 1'b1 || busy_cnt_o !== 6'd1) begin
      miscompares++;
      $display("FAIL areset_pre: busy %b cnt %0d want 1 1", rd_busy_o[0], busy_cnt_o);
    end
    #1 rst_i = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (busy_cnt_o !== '0 || rd_busy_o !== 2'b00 || rd_data_o !== '0) begin
      miscompares++;
      $display("FAIL areset_immediate: cnt %0d busy %b data %h want 0 00 0",
               busy_cnt_o, rd_busy_o, rd_data_o);
    end
    #1 rst_i = 1'b1;
    idle(9, 5);
    vectors++;
    if (busy_cnt_o !== '0 || rd_busy_o !== 2'b00 || rd_data_o !== '0) begin
      miscompares++;
      $display("FAIL areset_after: cnt %0d busy %b data %h want 0 00 0",
               busy_cnt_o, rd_busy_o, rd_data_o);
    end
  endtask

  task automatic test_random();
    int a0, a1, wa, aa;
    for (int n = 0; n < 400; n++) begin
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      aa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      a0 = $urandom_range(0, 7);
      a1 = ($urandom_range(0, 1) == 0) ? wa : $urandom_range(0, 31);
      drive(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 2) != 0), aa,
            1'($urandom_range(0, 19) == 0), a0, a1);
      vectors++;
      if (rd_data_o[31:0] !== m_rd_data(a0)) begin
        miscompares++;
        $display("FAIL rand_rd0 cyc %0d: got %h want %h", n, rd_data_o[31:0], m_rd_data(a0));
      end
      vectors++;
      if (rd_data_o[63:32] !== m_rd_data(a1)) begin
        miscompares++;
        $display("FAIL rand_rd1 cyc %0d: got %h want %h", n, rd_data_o[63:32], m_rd_data(a1));
      end
      vectors++;
      if (rd_busy_o !== {m_rd_busy(a1), m_rd_busy(a0)}) begin
        miscompares++;
        $display("FAIL rand_busy cyc %0d: got %b want %b", n, rd_busy_o,
                 {m_rd_busy(a1), m_rd_busy(a0)});
      end
      vectors++;
      if (alloc_ok_o !== m_alloc_ok()) begin
        miscompares++;
        $display("FAIL rand_alloc_ok cyc %0d: got %b want %b", n, alloc_ok_o, m_alloc_ok());
      end
      vectors++;
      if (int'(busy_cnt_o) !== m_count()) begin
        miscompares++;
        $display("FAIL rand_cnt cyc %0d: got %0d want %0d", n, busy_cnt_o, m_count());
      end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_i        = 1'b0;
    rd_addr_i    = '0;
    wr_en_i      = 1'b0;
    wr_addr_i    = '0;
    wr_data_i    = '0;
    alloc_en_i   = 1'b0;
    alloc_addr_i = '0;
    flush_i      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    test_reset();
    test_bypass();
    test_zero_reg();
    test_alloc();
    test_flush();
    test_async_reset();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
